debounce_pulso: RTL and testbench
=================================

# debounce_pulso

Upstream conditioning stage for the 4-bit synchronous counter: takes a raw, asynchronous, bouncing pushbutton and produces a clean debounced level plus a single-cycle count pulse. The counter consumes `pulso` as its count enable, so each physical press advances it exactly once. Optional auto-repeat emits further pulses while the button is held.

## Interface
- `N_ESTAVEL`, 16: consecutive stable samples required to accept a level change; legal range ≥ 2.
- `REPETE_ATRASO`, 0: cycles held in PRESSIONADO before the first repeat pulse; 0 disables auto-repeat.
- `REPETE_PERIODO`, 8: cycles between subsequent repeat pulses; legal range ≥ 2; ignored when repeat is disabled.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `botao`  in  1  raw button, asynchronous to `clock`, active-high, may bounce.
- `nivel`  out  1  debounced button level.
- `pulso`  out  1  one-cycle strobe per accepted press and per repeat; feeds the counter enable.
- `repetindo`  out  1  high while auto-repeat pulses are being generated.

## Operation
- `botao` passes through a 2-flop synchronizer; the FSM sees only the synchronized `s`.
- FSM states: SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTA.
  - SOLTO: `s`=1 -> CONFIRMA_PRESS, stability counter cleared.
  - CONFIRMA_PRESS: `s`=0 on any cycle -> SOLTO, counter cleared (glitch rejected, no pulse). After N_ESTAVEL consecutive `s`=1 samples -> PRESSIONADO; `nivel`<=1, `pulso`<=1 for one cycle; hold counter cleared.
  - PRESSIONADO: `s`=0 -> CONFIRMA_SOLTA. Hold counter runs while in PRESSIONADO and generates repeat pulses as described below.
  - CONFIRMA_SOLTA: `s`=1 on any cycle -> PRESSIONADO (hold counter and repeat phase preserved, no extra pulse). After N_ESTAVEL consecutive `s`=0 samples -> SOLTO; `nivel`<=0, `repetindo`<=0, no pulse.
- Auto-repeat (REPETE_ATRASO>0):
  - The first repeat pulse fires REPETE_ATRASO cycles after the press pulse.
  - Further pulses fire every REPETE_PERIODO cycles after that.
  - `repetindo` goes high with the first repeat pulse.
  - The hold counter saturates and never wraps back into a spurious pulse.
  - Pulses are suppressed while in CONFIRMA_SOLTA.
- `pulso` is never high on two consecutive cycles.
- Reset mid-operation (any state, any counter value): all outputs 0, state SOLTO, counters and synchronizer cleared immediately. A button still held at reset release is treated as a new press after full debounce.

## Timing
- Reset values: `nivel`=0, `pulso`=0, `repetindo`=0, state SOLTO, all counters 0, synchronizer flops 0.
- All outputs are registered; no combinational path from `botao` to any output.
- Press latency:
  - `botao` first sampled high at edge 0 and held.
  - `nivel` and `pulso` rise at edge N_ESTAVEL+2.
  - `pulso` falls at edge N_ESTAVEL+3.
- Release latency: `nivel` falls at edge N_ESTAVEL+2 after `botao` is first sampled low and held.
- Any bounce shorter than N_ESTAVEL samples produces no change on any output.
- Repeat pulses with REPETE_ATRASO=A and REPETE_PERIODO=P: at press-pulse edge + A, then + A+P, + A+2P, ...

## Structure
- Shared package `debounce_pkg`:
  - state enum `estado_t` with the four states;
  - helper localparams for counter widths: `$clog2(N_ESTAVEL+1)`, and `$clog2(max(REPETE_ATRASO,REPETE_PERIODO)+1)`.
- One sub-module, `sincronizador_2ff`: 2-flop synchronizer with async active-low reset, reusable for other async inputs.
- Top level contains the FSM, the stability counter and the hold/repeat counter.

## Test plan
- Reset check: assert `reset`=0 mid-count with `botao`=1 held -> all outputs 0 immediately. Release reset with the button still held -> single `pulso` at edge N_ESTAVEL+2.
- Clean press, N_ESTAVEL=4: `botao` 0->1 held 20 cycles, then 0 -> `pulso`=1 exactly one cycle at edge 6. `nivel` high from edge 6 until 6 edges after release.
- Bounce rejection, N_ESTAVEL=4: `botao` toggles 1,0,1,1,0,1 (each 1 cycle), then stays 0 -> `pulso` and `nivel` remain 0 throughout.
- Release bounce, N_ESTAVEL=4: while pressed, `botao` drops for 2 cycles then returns to 1 -> `nivel` stays 1 and no second pulse.
- Auto-repeat, N_ESTAVEL=4, A=10, P=3, held 30 cycles after the press pulse -> pulses at +0, +10, +13, +16, ..., +28. `repetindo` rises at +10 and clears on debounced release.
- Integration with `contador_4bits`, `pulso` driving the enable: 5 clean presses -> counter reads 5. 17 presses -> counter wraps to 1.

Source files
------------

// File: rtl/debounce_pulso_pkg.sv
// Shared types and width helpers for the pushbutton debouncer and its reusable synchronizer.
// No logic; widths are derived from the instantiating module's parameters.
package debounce_pkg;

  typedef enum logic [1:0] {
    SOLTO          = 2'd0,
    CONFIRMA_PRESS = 2'd1,
    PRESSIONADO    = 2'd2,
    CONFIRMA_SOLTA = 2'd3
  } estado_t;

  function automatic int maximo(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int largura_estavel(input int n_estavel);
    return $clog2(n_estavel + 1);
  endfunction

  function automatic int largura_repete(input int atraso, input int periodo);
    return $clog2(maximo(atraso, periodo) + 1);
  endfunction

endpackage

// File: rtl/debounce_pulso_if.sv
// Button-side bundle: raw button in, debounced level, count strobe and repeat flag out.
interface debounce_pulso_if;
  logic botao;
  logic nivel;
  logic pulso;
  logic repetindo;

  modport master (output botao, input nivel, input pulso, input repetindo);
  modport slave  (input botao, output nivel, output pulso, output repetindo);
endinterface

// File: rtl/debounce_pulso_sincronizador.sv
// Two-flop synchronizer for a single asynchronous input; two cycles of latency.
module sincronizador_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sinc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sinc_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/debounce_pulso.sv
// Pushbutton debouncer: level + one-cycle count strobe per press, optional auto-repeat.
// Press/release accepted N_ESTAVEL+2 edges after the raw input settles; all outputs registered.
module debounce_pulso
  import debounce_pkg::*;
#(
  parameter int N_ESTAVEL      = 16,
  parameter int REPETE_ATRASO  = 0,
  parameter int REPETE_PERIODO = 8
) (
  input  logic             clock,
  input  logic             reset,
  debounce_pulso_if.slave  bp
);

  localparam int WE = largura_estavel(N_ESTAVEL);
  localparam int WR = largura_repete(REPETE_ATRASO, REPETE_PERIODO);
  localparam logic [WE-1:0] ESTAVEL_FIM = WE'(N_ESTAVEL - 1);
  localparam logic [WR-1:0] ATRASO_FIM  = WR'((REPETE_ATRASO > 0) ? REPETE_ATRASO - 1 : 0);
  localparam logic [WR-1:0] PERIODO_FIM = WR'(REPETE_PERIODO - 1);
  localparam logic [WR-1:0] HOLD_MAX    = '1;
  localparam bit            REPETE_ON   = (REPETE_ATRASO > 0);

  logic          s;
  estado_t       estado_q, estado_d;
  logic [WE-1:0] cnt_q, cnt_d;
  logic [WR-1:0] hold_q, hold_d;
  logic          nivel_q, nivel_d;
  logic          pulso_q, pulso_d;
  logic          repetindo_q, repetindo_d;
  logic          repete_vence;

  sincronizador_2ff u_sinc (
    .clk   (clock),
    .rst_n (reset),
    .d_i   (bp.botao),
    .q_o   (s)
  );

  // >= rather than == so a repeat blocked by the previous strobe fires one cycle later
  assign repete_vence = !pulso_q &&
                        ((!repetindo_q && (hold_q >= ATRASO_FIM)) ||
                         ( repetindo_q && (hold_q >= PERIODO_FIM)));

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    nivel_d     = nivel_q;
    pulso_d     = 1'b0;
    repetindo_d = repetindo_q;
    unique case (estado_q)
      SOLTO: begin
        if (s) begin
          estado_d = CONFIRMA_PRESS;
          cnt_d    = '0;
        end
      end
      CONFIRMA_PRESS: begin
        if (!s) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else if (cnt_q == ESTAVEL_FIM) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
          hold_d   = '0;
          nivel_d  = 1'b1;
          pulso_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSIONADO: begin
        if (!s) begin
          estado_d = CONFIRMA_SOLTA;
          cnt_d    = '0;
        end else if (REPETE_ON) begin
          if (repete_vence) begin
            pulso_d     = 1'b1;
            repetindo_d = 1'b1;
            hold_d      = '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      CONFIRMA_SOLTA: begin
        // hold counter is frozen here so a bounce back resumes the repeat phase
        if (s) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_q == ESTAVEL_FIM) begin
          estado_d    = SOLTO;
          cnt_d       = '0;
          nivel_d     = 1'b0;
          repetindo_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= SOLTO;
      cnt_q       <= '0;
      hold_q      <= '0;
      nivel_q     <= 1'b0;
      pulso_q     <= 1'b0;
      repetindo_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      nivel_q     <= nivel_d;
      pulso_q     <= pulso_d;
      repetindo_q <= repetindo_d;
    end
  end

  assign bp.nivel     = nivel_q;
  assign bp.pulso     = pulso_q;
  assign bp.repetindo = repetindo_q;

endmodule

// File: tb/tb_debounce_pulso.sv
// Directed bench: one debouncer without repeat (A) and one with A=10/P=3 (B), both N_ESTAVEL=4.
module tb_debounce_pulso;

  logic clock;
  logic reset;
  logic [3:0] contador;
  int checks;
  int errors;

  debounce_pulso_if ifa ();
  debounce_pulso_if ifb ();

  debounce_pulso #(.N_ESTAVEL(4), .REPETE_ATRASO(0), .REPETE_PERIODO(8)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bp    (ifa)
  );

  debounce_pulso #(.N_ESTAVEL(4), .REPETE_ATRASO(10), .REPETE_PERIODO(3)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bp    (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // stand-in for the 4-bit counter, enabled by A's strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) contador <= 4'd0;
    else if (ifa.pulso) contador <= contador + 4'd1;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s obs=%0h esp=%0h", tag, obs, esp);
    end
  endtask

  // Drives one button for n edges; edge 0 is the first edge sampling the new value.
  // Checks {nivel,pulso,repetindo} after every edge against the hand-computed schedule.
  task automatic janela(input int dut, input string tag, input logic b, input int n,
                        input int p0, input int p1, input int per,
                        input logic niv_ini, input int niv_muda,
                        input logic rep_ini, input int rep_muda);
    logic esp_p, esp_n, esp_r;
    if (dut == 0) ifa.botao = b;
    else          ifb.botao = b;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      esp_p = (k == p0) || ((p1 >= 0) && (k >= p1) && (((k - p1) % per) == 0));
      esp_n = (k >= niv_muda) ? ~niv_ini : niv_ini;
      esp_r = (k >= rep_muda) ? ~rep_ini : rep_ini;
      if (dut == 0)
        verifica($sformatf("%s@%0d", tag, k), {29'd0, ifa.nivel, ifa.pulso, ifa.repetindo},
                 {29'd0, esp_n, esp_p, esp_r});
      else
        verifica($sformatf("%s@%0d", tag, k), {29'd0, ifb.nivel, ifb.pulso, ifb.repetindo},
                 {29'd0, esp_n, esp_p, esp_r});
    end
  endtask

  task automatic aplica_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic pressiona_a();
    janela(0, "cnt_press", 1'b1, 8, 6, -1, 1, 1'b0, 6, 1'b0, 99);
    janela(0, "cnt_solta", 1'b0, 8, -1, -1, 1, 1'b1, 6, 1'b0, 99);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    ifa.botao = 1'b0;
    ifb.botao = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    verifica("reset_a", {29'd0, ifa.nivel, ifa.pulso, ifa.repetindo}, 32'd0);
    verifica("reset_b", {29'd0, ifb.nivel, ifb.pulso, ifb.repetindo}, 32'd0);
    reset = 1'b1;

    // clean press: strobe exactly at edge 6, level falls 6 edges after release
    janela(0, "press", 1'b1, 20, 6, -1, 1, 1'b0, 6, 1'b0, 99);
    janela(0, "solta", 1'b0, 10, -1, -1, 1, 1'b1, 6, 1'b0, 99);

    // bounce 1,0,1,1,0,1 then low: nothing moves
    janela(0, "bounce", 1'b1, 1, -1, -1, 1, 1'b0, 99, 1'b0, 99);
    janela(0, "bounce", 1'b0, 1, -1, -1, 1, 1'b0, 99, 1'b0, 99);
    janela(0, "bounce", 1'b1, 2, -1, -1, 1, 1'b0, 99, 1'b0, 99);
    janela(0, "bounce", 1'b0, 1, -1, -1, 1, 1'b0, 99, 1'b0, 99);
    janela(0, "bounce", 1'b1, 1, -1, -1, 1, 1'b0, 99, 1'b0, 99);
    janela(0, "bounce", 1'b0, 12, -1, -1, 1, 1'b0, 99, 1'b0, 99);

    // release bounce while pressed: level held, no second strobe
    janela(0, "rb_press", 1'b1, 10, 6, -1, 1, 1'b0, 6, 1'b0, 99);
    janela(0, "rb_glitch", 1'b0, 2, -1, -1, 1, 1'b1, 99, 1'b0, 99);
    janela(0, "rb_volta", 1'b1, 12, -1, -1, 1, 1'b1, 99, 1'b0, 99);
    janela(0, "rb_solta", 1'b0, 10, -1, -1, 1, 1'b1, 6, 1'b0, 99);

    // auto-repeat: strobes at +0, +10, +13, ... +28 relative to edge 6
    janela(1, "rep", 1'b1, 35, 6, 16, 3, 1'b0, 6, 1'b0, 16);
    janela(1, "rep_solta", 1'b0, 10, -1, -1, 1, 1'b1, 6, 1'b1, 6);

    // reset in the middle of repeating, button still held through release of reset
    ifa.botao = 1'b1;
    janela(1, "rst_pre", 1'b1, 20, 6, 16, 3, 1'b0, 6, 1'b0, 16);
    reset = 1'b0;
    #2;
    verifica("rst_async_a", {29'd0, ifa.nivel, ifa.pulso, ifa.repetindo}, 32'd0);
    verifica("rst_async_b", {29'd0, ifb.nivel, ifb.pulso, ifb.repetindo}, 32'd0);
    @(posedge clock);
    #1;
    verifica("rst_hold_b", {29'd0, ifb.nivel, ifb.pulso, ifb.repetindo}, 32'd0);
    reset = 1'b1;
    janela(1, "rst_rel", 1'b1, 14, 6, -1, 1, 1'b0, 6, 1'b0, 99);
    ifa.botao = 1'b0;
    janela(1, "rst_solta", 1'b0, 10, -1, -1, 1, 1'b1, 6, 1'b0, 99);

    // counter integration
    aplica_reset();
    verifica("contador0", {28'd0, contador}, 32'd0);
    for (int i = 0; i < 5; i++) pressiona_a();
    verifica("contador5", {28'd0, contador}, 32'd5);
    for (int i = 0; i < 12; i++) pressiona_a();
    verifica("contador17", {28'd0, contador}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
